// File: rtl/fft_ctrl_pkg.sv
// Shared FFT control definitions: direction/mode encodings and terminal-value helper
// used by the modulo counter and the address generator.
package fft_ctrl_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int unsigned MAX_WIDTH = 16;

  // Terminal count for a programmable modulus; modulus 0 selects the full 2^width range.
  function automatic logic [MAX_WIDTH-1:0] calc_last(input logic [MAX_WIDTH-1:0] modulus,
                                                     input int unsigned          width);
    logic [MAX_WIDTH:0] ones;
    ones = (17'd1 << width) - 17'd1;
    return (modulus == '0) ? ones[MAX_WIDTH-1:0] : modulus - 16'd1;
  endfunction

endpackage

// File: rtl/bit_reverse_n.sv
// Purely combinational bit-order reversal, shared by the modulo counter and the
// FFT reorder buffer.
module bit_reverse_n #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign data_o[i] = data_i[WIDTH-1-i];
  end

endmodule

// File: rtl/counter_mod_n.sv
// Run-time programmable modulo counter: up/down, wrap or saturate, parallel load,
// synchronous clear, cascadable terminal-count output and a bit-reversed count.
module counter_mod_n
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_rev,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] last;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  assign last = WIDTH'(calc_last(MAX_WIDTH'(modulus), WIDTH));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (sclr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val <= last) ? load_val : last;
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (count_q < last) begin
          count_d = count_q + 1'b1;
        end else if (sat_mode == MODE_WRAP) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = last;
        end
      end else begin
        // A count left above a freshly shrunk modulus snaps to last without a wrap.
        if (count_q > last) begin
          count_d = last;
        end else if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else if (sat_mode == MODE_WRAP) begin
          count_d = last;
          wrap_d  = 1'b1;
        end else begin
          count_d = '0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= RESET_VAL;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign tc    = en & ((dir == DIR_UP) ? (count_q >= last) : (count_q == '0));
  assign count = count_q;
  assign wrap  = wrap_q;

  bit_reverse_n #(.WIDTH(WIDTH)) u_bit_reverse (
    .data_i (count_q),
    .data_o (count_rev)
  );

endmodule

// File: tb/tb_counter_mod_n.sv
// Scoreboard bench for counter_mod_n: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_counter_mod_n;

  typedef enum logic {K_MAIN, K_CASC} kind_e;

  typedef struct {
    kind_e      kind;
    string      name;
    logic [3:0] cnt;
    logic       wrp;
    logic       tcv;
    logic [3:0] rev;
    logic [7:0] comb;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       clk = 1'b0;
  logic       clr, en, sclr, load, dir, sat_mode;
  logic [3:0] load_val, modulus;
  logic [3:0] count, count_rev;
  logic       tc, wrap;

  logic       clr_c, en_c;
  logic [3:0] lo_count, lo_rev, hi_count, hi_rev;
  logic       lo_tc, lo_wrap, hi_tc, hi_wrap;

  always #5 clk = ~clk;

  counter_mod_n #(.WIDTH(4), .RESET_VAL(4'd3)) u_dut (
    .clk(clk), .clr(clr), .en(en), .sclr(sclr), .load(load), .load_val(load_val),
    .dir(dir), .sat_mode(sat_mode), .modulus(modulus),
    .count(count), .count_rev(count_rev), .tc(tc), .wrap(wrap)
  );

  counter_mod_n #(.WIDTH(4), .RESET_VAL(4'd0)) u_lo (
    .clk(clk), .clr(clr_c), .en(en_c), .sclr(1'b0), .load(1'b0), .load_val(4'd0),
    .dir(1'b1), .sat_mode(1'b0), .modulus(4'd0),
    .count(lo_count), .count_rev(lo_rev), .tc(lo_tc), .wrap(lo_wrap)
  );

  counter_mod_n #(.WIDTH(4), .RESET_VAL(4'd0)) u_hi (
    .clk(clk), .clr(clr_c), .en(lo_tc), .sclr(1'b0), .load(1'b0), .load_val(4'd0),
    .dir(1'b1), .sat_mode(1'b0), .modulus(4'd0),
    .count(hi_count), .count_rev(hi_rev), .tc(hi_tc), .wrap(hi_wrap)
  );

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.kind == K_MAIN) begin
        check({e.name, ".count"}, 16'(count), 16'(e.cnt));
        check({e.name, ".wrap"},  16'(wrap),  16'(e.wrp));
        check({e.name, ".tc"},    16'(tc),    16'(e.tcv));
        check({e.name, ".rev"},   16'(count_rev), 16'(e.rev));
      end else begin
        check({e.name, ".comb"},  16'({hi_count, lo_count}), 16'(e.comb));
        check({e.name, ".lo_tc"}, 16'(lo_tc), 16'(e.tcv));
      end
    end
  end

  // Queue the observation expected at the coming negedge, then advance one clock.
  task automatic step_rev(input string name, input logic [3:0] c, input logic w,
                          input logic t, input logic [3:0] r);
    exp_t e;
    e.kind = K_MAIN; e.name = name; e.cnt = c; e.wrp = w; e.tcv = t; e.rev = r; e.comb = '0;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic cyc(input string name, input logic [3:0] c, input logic w, input logic t);
    step_rev(name, c, w, t, rev4(c));
  endtask

  task automatic cyc_casc(input string name, input logic [7:0] comb, input logic t);
    exp_t e;
    e.kind = K_CASC; e.name = name; e.cnt = '0; e.wrp = 1'b0; e.tcv = t; e.rev = '0; e.comb = comb;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] prev;
    clr = 1'b1; en = 1'b0; sclr = 1'b0; load = 1'b0; load_val = '0;
    dir = 1'b1; sat_mode = 1'b0; modulus = 4'd0;
    clr_c = 1'b1; en_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset value, then a mid-count asynchronous clear.
    clr = 1'b0; en = 1'b1;
    cyc("pre", 4'd3, 1'b0, 1'b0);
    cyc("pre", 4'd4, 1'b0, 1'b0);
    cyc("pre", 4'd5, 1'b0, 1'b0);
    clr = 1'b1;
    cyc("clr_async", 4'd3, 1'b0, 1'b0);
    clr = 1'b0;
    for (int i = 0; i < 13; i++) cyc("up_full", 4'(3 + i), 1'b0, (i == 12));
    cyc("up_full_wrap", 4'd0, 1'b1, 1'b0);
    en = 1'b0;
    cyc("hold", 4'd1, 1'b0, 1'b0);

    // Programmable modulus and shrinking it mid-run.
    sclr = 1'b1;
    cyc("sclr", 4'd1, 1'b0, 1'b0);
    sclr = 1'b0; modulus = 4'd10; en = 1'b1;
    for (int i = 0; i < 10; i++) cyc("mod10", 4'(i), 1'b0, (i == 9));
    cyc("mod10_wrap", 4'd0, 1'b1, 1'b0);
    for (int i = 1; i < 7; i++) cyc("mod10_run", 4'(i), 1'b0, 1'b0);
    modulus = 4'd5;
    cyc("shrink_up", 4'd7, 1'b0, 1'b1);
    modulus = 4'd10; load = 1'b1; load_val = 4'd7; en = 1'b0;
    cyc("shrink_wrap", 4'd0, 1'b1, 1'b0);
    load = 1'b0; modulus = 4'd5; dir = 1'b0; en = 1'b1;
    cyc("dn_above", 4'd7, 1'b0, 1'b0);

    // Down-count wrap, then saturation at zero.
    modulus = 4'd6; load = 1'b1; load_val = 4'd2; en = 1'b0;
    cyc("dn_above_res", 4'd4, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    cyc("dn6", 4'd2, 1'b0, 1'b0);
    cyc("dn6", 4'd1, 1'b0, 1'b0);
    cyc("dn6", 4'd0, 1'b0, 1'b1);
    cyc("dn6_wrap", 4'd5, 1'b1, 1'b0);
    sclr = 1'b1;
    cyc("dn6", 4'd4, 1'b0, 1'b0);
    sclr = 1'b0; sat_mode = 1'b1;
    cyc("sat_dn", 4'd0, 1'b0, 1'b1);
    cyc("sat_dn", 4'd0, 1'b0, 1'b1);
    load = 1'b1; load_val = 4'd5; dir = 1'b1;
    cyc("load_en", 4'd0, 1'b0, 1'b0);
    load = 1'b0;
    cyc("sat_up", 4'd5, 1'b0, 1'b1);
    cyc("sat_up", 4'd5, 1'b0, 1'b1);

    // Priority sclr > load > en, and load clamping.
    modulus = 4'd0; sat_mode = 1'b0; load = 1'b1; load_val = 4'd9; en = 1'b0;
    cyc("pri_setup", 4'd5, 1'b0, 1'b0);
    sclr = 1'b1; load_val = 4'd12; en = 1'b1;
    cyc("pri_all", 4'd9, 1'b0, 1'b0);
    sclr = 1'b0; modulus = 4'd8;
    cyc("pri_sclr", 4'd0, 1'b0, 1'b0);
    load = 1'b0; en = 1'b0;
    cyc("pri_clamp", 4'd7, 1'b0, 1'b0);

    // modulus = 1: stuck at 0, wrapping every cycle.
    modulus = 4'd1; en = 1'b1;
    cyc("m1", 4'd7, 1'b0, 1'b1);
    cyc("m1", 4'd0, 1'b1, 1'b1);
    cyc("m1", 4'd0, 1'b1, 1'b1);
    en = 1'b0;
    cyc("m1_off", 4'd0, 1'b1, 1'b0);
    cyc("m1_off", 4'd0, 1'b0, 1'b0);

    // Bit reverse: two hand vectors, then a full sweep against the reference.
    modulus = 4'd0; load = 1'b1; load_val = 4'b0001;
    cyc("rev_setup", 4'd0, 1'b0, 1'b0);
    load_val = 4'b0110;
    step_rev("rev_0001", 4'b0001, 1'b0, 1'b0, 4'b1000);
    load_val = 4'd0;
    step_rev("rev_0110", 4'b0110, 1'b0, 1'b0, 4'b0110);
    prev = 4'd0;
    for (int v = 1; v < 16; v++) begin
      load_val = 4'(v);
      cyc("brev", prev, 1'b0, 1'b0);
      prev = 4'(v);
    end
    load = 1'b0;
    cyc("brev", 4'd15, 1'b0, 1'b0);

    // Cascade: low stage tc drives high stage en.
    clr_c = 1'b0; en_c = 1'b1;
    for (int i = 0; i < 300; i++) cyc_casc("casc", 8'(i), ((i % 16) == 15));
    en_c = 1'b0;
    cyc_casc("casc_final", 8'd44, 1'b0);

    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_mod_n.md
Name: counter_mod_n

Overview:
- Parametrised, run-time-programmable modulo counter. It succeeds the fixed mod-16 up-counter used for FFT sample, twiddle and stage indexing.
- Adds generic width, programmable modulus, up/down direction, wrap-or-saturate mode, parallel load, synchronous clear and a cascade carry-out.
- Provides a bit-reversed copy of the count for FFT input/output reordering. Instantiated by the FFT address generator and the stage sequencer.

Parameters:
- WIDTH, 4, counter width in bits (range 2..16).
- RESET_VAL, 0, value of count after clr; must be less than 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous, active-high reset.
- en  input  1  count enable; also acts as cascade carry-in.
- sclr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- dir  input  1  1 = count up, 0 = count down.
- sat_mode  input  1  1 = saturate at terminal value, 0 = wrap.
- modulus  input  WIDTH  count range is 0..modulus-1; modulus = 0 means the full 2^WIDTH range.
- count  output  WIDTH  current count (registered).
- count_rev  output  WIDTH  count with bit order reversed (combinational from count).
- tc  output  1  terminal-count carry-out (combinational).
- wrap  output  1  one-cycle registered pulse, asserted the cycle after a wrap.

Behaviour:
- Reset: clr asynchronous, active-high. While clr = 1: count = RESET_VAL, wrap = 0. Asserting clr mid-operation aborts immediately; counting resumes from RESET_VAL on the first edge after release.
- last = modulus - 1, or all-ones when modulus = 0.
- Synchronous priority, highest first: sclr > load > en. With none of them asserted, count holds.
- sclr: count <= 0; wrap <= 0.
- load: count <= load_val if load_val <= last, otherwise count <= last (clamp); wrap <= 0. Load works whether or not en is high.
- en, dir = 1:
  - count < last: count <= count + 1.
  - count >= last, sat_mode = 0: count <= 0, wrap <= 1.
  - count >= last, sat_mode = 1: count holds at last (forced to last if above it), wrap <= 0.
- en, dir = 0:
  - 0 < count <= last: count <= count - 1.
  - count > last (modulus shrank while running): count <= last, no wrap.
  - count = 0, sat_mode = 0: count <= last, wrap <= 1.
  - count = 0, sat_mode = 1: count holds at 0, wrap <= 0.
- wrap: high for exactly the one cycle following each wrap event; 0 in every other cycle.
- tc = en AND (count >= last when dir = 1; count = 0 when dir = 0).
  - tc is independent of sat_mode, sclr and load.
  - Chaining: one stage's tc drives the next stage's en, and all stages share clk. The chain then behaves as a single wide counter, with zero added latency.
- modulus, dir and sat_mode are sampled every cycle and may change at any time. Their effect is on the next edge only; no internal state depends on earlier values.
- modulus = 1: last = 0, so count stays 0 and tc = en. With sat_mode = 0 and en = 1, wrap pulses every cycle.
- count_rev[i] = count[WIDTH-1-i]. It reverses all WIDTH bits regardless of modulus; callers mask the result themselves.
- All arithmetic is unsigned, WIDTH bits, with no overflow beyond the wrap rules above.

Decomposition:
- Shared package fft_ctrl_pkg holds:
  - DIR_UP = 1 and DIR_DN = 0.
  - MODE_WRAP = 0 and MODE_SAT = 1.
  - A function computing last from modulus, reused by the address generator.
- Sub-module bit_reverse_n (parameter WIDTH, purely combinational) produces count_rev. The FFT reorder buffer reuses it.
- Next-state logic and registers stay inline in counter_mod_n.

Test Plan:
- Reset and basic count: WIDTH = 4, RESET_VAL = 3. Assert clr mid-count -> count = 3 immediately, with no clock edge. Release; modulus = 0, dir = 1, en = 1 for 14 cycles -> count goes 3..15, then 0. tc = 1 at 15; wrap = 1 only in the cycle count = 0 is first seen.
- Programmable modulus: modulus = 10, up, wrap -> sequence 0..9, 0. Drop modulus to 5 while count = 7 -> next count = 0 with wrap = 1. Down-count from count = 7 with modulus = 5 -> next count = 4, no wrap.
- Down-count and saturation: dir = 0, sat_mode = 0, modulus = 6, from 2 -> 1, 0, 5 (wrap). sat_mode = 1 -> holds at 0, tc = 1, wrap = 0.
- Priority: sclr = load = en = 1 with count = 9 -> count = 0. load = en = 1 with load_val = 12 and modulus = 8 -> count = 7 (clamped).
- Cascade: two 4-bit instances chained through tc -> en, en = 1 for 300 cycles -> combined value = 300 mod 256 = 44. The high stage increments only when the low stage reads 15.
- Bit reverse: WIDTH = 4, count = 4'b0001 -> count_rev = 4'b1000; count = 4'b0110 -> count_rev = 4'b0110. Sweep all 16 values and compare against a reference model.
